// File: rtl/led_strip_tx_if.sv
// Control and pixel handshake between a frame source (master) and led_strip_tx (slave).
interface led_strip_tx_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned LW     = 11
);
  logic                 start;
  logic [LW-1:0]        led_num;
  logic [4:0]           brightness;
  logic                 pix_valid;
  logic [NUM_CH*24-1:0] pix_data;
  logic                 pix_ready;
  logic                 busy;
  logic                 done;
  logic                 underrun;

  modport master (
    output start, led_num, brightness, pix_valid, pix_data,
    input  pix_ready, busy, done, underrun
  );

  modport slave (
    input  start, led_num, brightness, pix_valid, pix_data,
    output pix_ready, busy, done, underrun
  );
endinterface

// File: rtl/led_strip_tx.sv
// Multi-lane APA102-style LED strip transmitter: start frame, per-LED words and end frame
// shifted out MSB first on per-strip sdo lanes with a shared cko.
module led_strip_tx #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned MAX_LED  = 1024,
  parameter int unsigned DIV_CNT  = 5,
  parameter int unsigned WAIT_CNT = 5,
  localparam int unsigned LW      = $clog2(MAX_LED + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  led_strip_tx_if.slave     bus,
  output logic              cko,
  output logic [NUM_CH-1:0] sdo
);

  localparam int unsigned PER    = 2 * DIV_CNT;
  localparam int unsigned PW     = $clog2(PER);
  localparam int unsigned MaxEnd = 32 + 8 * ((MAX_LED + 15) / 16);
  localparam int unsigned BW     = $clog2(MaxEnd + 1);

  typedef enum logic [2:0] {
    StIdle, StPreWait, StStartFrm, StLedFrm, StEndFrm, StPostWait
  } state_e;

  state_e                   state_q, state_d;
  logic [PW-1:0]            phase_q, phase_d;
  logic [BW-1:0]            bit_q, bit_d;
  logic [LW-1:0]            word_q, word_d;
  logic [LW-1:0]            led_num_q, led_num_d;
  logic [4:0]               bright_q, bright_d;
  logic [NUM_CH-1:0][31:0]  sh_q, sh_d;
  logic                     cko_q, cko_d;
  logic                     pix_ready_q, pix_ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     underrun_q, underrun_d;

  logic          tick, last, led_next;
  logic [LW:0]   led_round;
  logic [BW-1:0] end_bits, seg_len;

  always_comb begin
    led_round = {1'b0, led_num_q} + (LW+1)'(15);
    end_bits  = BW'(32) + (BW'(led_round >> 4) << 3);
    case (state_q)
      StPreWait, StPostWait: seg_len = BW'(WAIT_CNT);
      StStartFrm, StLedFrm:  seg_len = BW'(32);
      StEndFrm:              seg_len = end_bits;
      default:               seg_len = BW'(1);
    endcase
    tick = (phase_q == PW'(PER - 1));
    last = (bit_q == seg_len - BW'(1));
    // True when the word boundary just ahead opens another LED word.
    led_next = (bit_q == BW'(31)) &&
               (((state_q == StStartFrm) && (led_num_q != '0)) ||
                ((state_q == StLedFrm) && (word_q != led_num_q - LW'(1))));
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    word_d      = word_q;
    led_num_d   = led_num_q;
    bright_d    = bright_q;
    sh_d        = sh_q;
    underrun_d  = underrun_q;
    done_d      = 1'b0;
    pix_ready_d = 1'b0;

    if (state_q == StIdle) begin
      phase_d = '0;
      bit_d   = '0;
      word_d  = '0;
      // A start coinciding with done is dropped so back-to-back refreshes stay separated.
      if (bus.start && !done_q) begin
        led_num_d  = (bus.led_num > LW'(MAX_LED)) ? LW'(MAX_LED) : bus.led_num;
        bright_d   = bus.brightness;
        underrun_d = 1'b0;
        if (WAIT_CNT == 0) begin
          state_d = StStartFrm;
          sh_d    = '0;
        end else begin
          state_d = StPreWait;
          sh_d    = '1;
        end
      end
    end else begin
      phase_d     = tick ? '0 : phase_q + PW'(1);
      pix_ready_d = (phase_q == PW'(PER - 2)) && led_next;
      if (tick) begin
        bit_d = bit_q + BW'(1);
        for (int i = 0; i < NUM_CH; i++) sh_d[i] = {sh_q[i][30:0], 1'b1};
        if (last) begin
          bit_d = '0;
          unique case (state_q)
            StPreWait: begin
              state_d = StStartFrm;
              sh_d    = '0;
            end
            StStartFrm, StLedFrm: begin
              if (led_next) begin
                state_d = StLedFrm;
                word_d  = (state_q == StStartFrm) ? '0 : word_q + LW'(1);
                for (int i = 0; i < NUM_CH; i++) begin
                  sh_d[i] = {3'b111, bright_q, bus.pix_valid ? bus.pix_data[24*i +: 24] : 24'h0};
                end
                if (!bus.pix_valid) underrun_d = 1'b1;
              end else begin
                state_d = StEndFrm;
                sh_d    = '1;
              end
            end
            StEndFrm: begin
              if (WAIT_CNT == 0) begin
                state_d = StIdle;
                done_d  = 1'b1;
              end else begin
                state_d = StPostWait;
                sh_d    = '1;
              end
            end
            StPostWait: begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end

    cko_d  = ((state_d == StStartFrm) || (state_d == StLedFrm) || (state_d == StEndFrm)) &&
             (phase_d >= PW'(DIV_CNT));
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      led_num_q   <= '0;
      bright_q    <= '0;
      sh_q        <= '1;
      cko_q       <= 1'b0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      word_q      <= word_d;
      led_num_q   <= led_num_d;
      bright_q    <= bright_d;
      sh_q        <= sh_d;
      cko_q       <= cko_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    sdo = '1;
    for (int i = 0; i < NUM_CH; i++) sdo[i] = sh_q[i][31];
  end

  assign cko          = cko_q;
  assign bus.pix_ready = pix_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_led_strip_tx.sv
// Directed bench for led_strip_tx: a 1-lane instance without idle padding and a 4-lane
// instance with two padding bit-periods, checked against a bit-stream model.
module tb_led_strip_tx;
  localparam int unsigned LW = 11;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  led_strip_tx_if #(.NUM_CH(1), .LW(LW)) bus_a ();
  led_strip_tx_if #(.NUM_CH(4), .LW(LW)) bus_b ();
  logic       cko_a, cko_b;
  logic [0:0] sdo_a;
  logic [3:0] sdo_b;

  led_strip_tx #(.NUM_CH(1), .MAX_LED(1024), .DIV_CNT(5), .WAIT_CNT(0)) u_dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a), .cko(cko_a), .sdo(sdo_a)
  );
  led_strip_tx #(.NUM_CH(4), .MAX_LED(1024), .DIV_CNT(5), .WAIT_CNT(2)) u_dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b), .cko(cko_b), .sdo(sdo_b)
  );

  // Pixel source for instance A: pix_valid follows a per-word mask.
  logic        clr_a = 1'b0, clr_b = 1'b0;
  logic [31:0] mask_a = '1;
  int          idx_a = 0;
  always @(posedge clk) begin
    if (clr_a) idx_a <= 0;
    else if (bus_a.pix_ready) idx_a <= idx_a + 1;
  end
  always_comb bus_a.pix_valid = mask_a[idx_a[4:0]];

  // Monitors sample on the falling edge; a bit is captured on each cko rise.
  bit         q_a[$];
  logic [3:0] q_b[$];
  int  cyc = 0;
  int  pr_a = 0, dn_a = 0, glitch_a = 0, hi_a = 0, st_cyc_a = 0, dn_cyc_a = 0;
  int  pr_b = 0, dn_b = 0, st_cyc_b = 0, dn_cyc_b = 0;
  bit  st_seen_a = 0, st_seen_b = 0;
  logic cko_a_p = 1'b0, cko_b_p = 1'b0;
  logic [0:0] sdo_a_p = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (clr_a) begin
      q_a.delete(); pr_a = 0; dn_a = 0; glitch_a = 0; hi_a = 0; st_seen_a = 0;
    end else begin
      if (bus_a.start && !st_seen_a) begin st_seen_a = 1; st_cyc_a = cyc; end
      if (cko_a && !cko_a_p) q_a.push_back(sdo_a[0]);
      if (cko_a) hi_a++;
      else begin
        if (cko_a_p && hi_a != 5) glitch_a++;
        hi_a = 0;
      end
      if (cko_a && sdo_a != sdo_a_p) glitch_a++;
      if (bus_a.pix_ready) pr_a++;
      if (bus_a.done) begin dn_a++; dn_cyc_a = cyc; end
    end
    if (clr_b) begin
      q_b.delete(); pr_b = 0; dn_b = 0; st_seen_b = 0;
    end else begin
      if (bus_b.start && !st_seen_b) begin st_seen_b = 1; st_cyc_b = cyc; end
      if (cko_b && !cko_b_p) q_b.push_back(sdo_b);
      if (bus_b.pix_ready) pr_b++;
      if (bus_b.done) begin dn_b++; dn_cyc_b = cyc; end
    end
    cko_a_p = cko_a;
    sdo_a_p = sdo_a;
    cko_b_p = cko_b;
  end

  bit exp_q[$];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic build_exp(input int n, input logic [4:0] br, input logic [31:0] mask,
                           input logic [23:0] pix);
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(1'b0);
    for (int k = 0; k < n; k++) begin
      w = {3'b111, br, mask[k] ? pix : 24'h0};
      for (int i = 31; i >= 0; i--) exp_q.push_back(w[i]);
    end
    for (int i = 0; i < 32 + 8 * ((n + 15) / 16); i++) exp_q.push_back(1'b1);
  endtask

  // Returns -1 when the captured stream equals the model, else the first differing index.
  function automatic int diff_a();
    int ns = int'(exp_q.size());
    int na = int'(q_a.size());
    for (int i = 0; i < ns && i < na; i++) if (q_a[i] != exp_q[i]) return i;
    if (na != ns) return (na < ns) ? na : ns;
    return -1;
  endfunction

  function automatic int diff_b(input int lane);
    int ns = int'(exp_q.size());
    int nb = int'(q_b.size());
    for (int i = 0; i < ns && i < nb; i++) if (q_b[i][lane] != exp_q[i]) return i;
    if (nb != ns) return (nb < ns) ? nb : ns;
    return -1;
  endfunction

  function automatic int refresh_len(input int n, input int w);
    return 10 * (2 * w + 32 + 32 * n + 32 + 8 * ((n + 15) / 16)) + 1;
  endfunction

  task automatic start_a(input int n, input logic [4:0] br, input logic [31:0] mask,
                         input logic [23:0] pix);
    bus_a.led_num    = LW'(n);
    bus_a.brightness = br;
    bus_a.pix_data   = pix;
    mask_a           = mask;
    clr_a = 1'b1; step(); step(); clr_a = 1'b0;
    bus_a.start = 1'b1; step(); bus_a.start = 1'b0;
  endtask

  task automatic wait_done_a(input int limit, input int poke);
    int c = 0;
    while (bus_a.done !== 1'b1 && c < limit) begin
      bus_a.start = (c == poke);
      step();
      c++;
    end
    bus_a.start = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if (cko_a !== 1'b0) begin bad++; $display("FAIL rst_cko_a: got %b want 0", cko_a); end
    total++; if (sdo_a !== 1'b1) begin bad++; $display("FAIL rst_sdo_a: got %b want 1", sdo_a); end
    total++;
    if ({bus_a.busy, bus_a.done, bus_a.pix_ready, bus_a.underrun} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_flags_a: got %b want 0000",
               {bus_a.busy, bus_a.done, bus_a.pix_ready, bus_a.underrun});
    end
    total++; if (sdo_b !== 4'hF) begin bad++; $display("FAIL rst_sdo_b: got %h want f", sdo_b); end
    total++;
    if ({cko_b, bus_b.busy, bus_b.done} !== 3'b000) begin
      bad++; $display("FAIL rst_flags_b: got %b want 000", {cko_b, bus_b.busy, bus_b.done});
    end
    rstn = 1'b1;
    step(); step();
  endtask

  task automatic test_basic();
    int d;
    build_exp(4, 5'h1F, '1, 24'h112233);
    start_a(4, 5'h1F, '1, 24'h112233);
    total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", bus_a.busy); end
    wait_done_a(3000, -1);
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", bus_a.busy); end
    step();
    d = diff_a();
    total++;
    if (d != -1) begin
      bad++; $display("FAIL basic_stream: first bad bit %0d, got %0d bits want %0d", d, q_a.size(), exp_q.size());
    end
    total++; if (pr_a != 4) begin bad++; $display("FAIL basic_pix_ready: got %0d want 4", pr_a); end
    total++; if (dn_a != 1) begin bad++; $display("FAIL basic_done: got %0d want 1", dn_a); end
    d = dn_cyc_a - st_cyc_a;
    total++;
    if (d < refresh_len(4, 0) - 1 || d > refresh_len(4, 0) + 1) begin
      bad++; $display("FAIL basic_len: got %0d want 2001", d);
    end
    total++; if (glitch_a != 0) begin bad++; $display("FAIL basic_timing: got %0d violations want 0", glitch_a); end
    total++; if (bus_a.underrun !== 1'b0) begin bad++; $display("FAIL basic_underrun: got %b want 0", bus_a.underrun); end
  endtask

  task automatic test_underrun();
    int d;
    int c = 0;
    build_exp(4, 5'h1F, 32'hFFFF_FFFD, 24'h112233);
    start_a(4, 5'h1F, 32'hFFFF_FFFD, 24'h112233);
    while (pr_a < 1 && c < 1000) begin step(); c++; end
    step();
    total++; if (bus_a.underrun !== 1'b0) begin bad++; $display("FAIL urun_early: got %b want 0", bus_a.underrun); end
    while (pr_a < 2 && c < 1000) begin step(); c++; end
    step();
    total++; if (bus_a.underrun !== 1'b1) begin bad++; $display("FAIL urun_set: got %b want 1", bus_a.underrun); end
    wait_done_a(3000, -1);
    step(); step();
    d = diff_a();
    total++;
    if (d != -1) begin
      bad++; $display("FAIL urun_stream: first bad bit %0d, got %0d bits want %0d", d, q_a.size(), exp_q.size());
    end
    total++; if (bus_a.underrun !== 1'b1) begin bad++; $display("FAIL urun_sticky: got %b want 1", bus_a.underrun); end
    build_exp(1, 5'h03, '1, 24'hABCDEF);
    start_a(1, 5'h03, '1, 24'hABCDEF);
    total++; if (bus_a.underrun !== 1'b0) begin bad++; $display("FAIL urun_clear: got %b want 0", bus_a.underrun); end
    wait_done_a(2000, -1);
    step();
    d = diff_a();
    total++;
    if (d != -1) begin
      bad++; $display("FAIL urun_next_stream: first bad bit %0d, got %0d bits want %0d", d, q_a.size(), exp_q.size());
    end
  endtask

  task automatic test_zero();
    int d;
    build_exp(0, 5'h1F, '1, 24'h112233);
    start_a(0, 5'h1F, '1, 24'h112233);
    wait_done_a(1000, -1);
    step();
    d = diff_a();
    total++;
    if (d != -1) begin
      bad++; $display("FAIL zero_stream: first bad bit %0d, got %0d bits want %0d", d, q_a.size(), exp_q.size());
    end
    total++; if (pr_a != 0) begin bad++; $display("FAIL zero_pix_ready: got %0d want 0", pr_a); end
    total++; if (dn_a != 1) begin bad++; $display("FAIL zero_done: got %0d want 1", dn_a); end
    d = dn_cyc_a - st_cyc_a;
    total++;
    if (d < refresh_len(0, 0) - 1 || d > refresh_len(0, 0) + 1) begin
      bad++; $display("FAIL zero_len: got %0d want 641", d);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    build_exp(2, 5'h0A, '1, 24'h5A6B7C);
    start_a(2, 5'h0A, '1, 24'h5A6B7C);
    wait_done_a(2000, 700);
    bus_a.start = 1'b1;
    step();
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL b2b_done_start: busy got %b want 0", bus_a.busy); end
    d = diff_a();
    total++;
    if (d != -1) begin
      bad++; $display("FAIL b2b_stream: first bad bit %0d, got %0d bits want %0d", d, q_a.size(), exp_q.size());
    end
    total++; if (dn_a != 1) begin bad++; $display("FAIL b2b_done: got %0d want 1", dn_a); end
    total++; if (pr_a != 2) begin bad++; $display("FAIL b2b_pix_ready: got %0d want 2", pr_a); end
    d = dn_cyc_a - st_cyc_a;
    total++;
    if (d < refresh_len(2, 0) - 1 || d > refresh_len(2, 0) + 1) begin
      bad++; $display("FAIL b2b_len: got %0d want 1361", d);
    end
    step();
    bus_a.start = 1'b0;
    total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL b2b_restart: busy got %b want 1", bus_a.busy); end
    wait_done_a(2000, -1);
    step(); step();
  endtask

  task automatic test_abort();
    int d;
    int pr_hold;
    start_a(4, 5'h1F, '1, 24'h112233);
    repeat (800) step();
    pr_hold = pr_a;
    rstn = 1'b0;
    #1;
    total++;
    if ({cko_a, sdo_a, bus_a.busy, bus_a.pix_ready} !== 4'b0100) begin
      bad++;
      $display("FAIL abort_outputs: cko/sdo/busy/ready got %b want 0100",
               {cko_a, sdo_a, bus_a.busy, bus_a.pix_ready});
    end
    repeat (20) step();
    total++; if (dn_a != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", dn_a); end
    total++; if (pr_a != pr_hold) begin bad++; $display("FAIL abort_no_ready: got %0d want %0d", pr_a, pr_hold); end
    rstn = 1'b1;
    repeat (3) step();
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL abort_idle: busy got %b want 0", bus_a.busy); end
    build_exp(3, 5'h10, '1, 24'hA5C3E1);
    start_a(3, 5'h10, '1, 24'hA5C3E1);
    wait_done_a(3000, -1);
    step();
    d = diff_a();
    total++;
    if (d != -1) begin
      bad++; $display("FAIL abort_rerun_stream: first bad bit %0d, got %0d bits want %0d", d, q_a.size(), exp_q.size());
    end
    total++; if (pr_a != 3) begin bad++; $display("FAIL abort_rerun_ready: got %0d want 3", pr_a); end
    total++; if (dn_a != 1) begin bad++; $display("FAIL abort_rerun_done: got %0d want 1", dn_a); end
  endtask

  task automatic test_multi_lane();
    int d;
    int c = 0;
    logic [23:0] px;
    bus_b.led_num    = LW'(1);
    bus_b.brightness = 5'h0A;
    bus_b.pix_data   = {24'h030303, 24'h020202, 24'h010101, 24'h000000};
    bus_b.pix_valid  = 1'b1;
    clr_b = 1'b1; step(); step(); clr_b = 1'b0;
    bus_b.start = 1'b1; step(); bus_b.start = 1'b0;
    total++;
    if ({bus_b.busy, cko_b, sdo_b} !== 6'b10_1111) begin
      bad++; $display("FAIL lane_prewait: busy/cko/sdo got %b want 101111", {bus_b.busy, cko_b, sdo_b});
    end
    repeat (15) step();
    total++; if (cko_b !== 1'b0) begin bad++; $display("FAIL lane_prewait_cko: got %b want 0", cko_b); end
    while (bus_b.done !== 1'b1 && c < 2000) begin step(); c++; end
    step();
    for (int ln = 0; ln < 4; ln++) begin
      px = {8'(ln), 8'(ln), 8'(ln)};
      build_exp(1, 5'h0A, '1, px);
      d = diff_b(ln);
      total++;
      if (d != -1) begin
        bad++; $display("FAIL lane%0d_stream: first bad bit %0d, got %0d bits want %0d", ln, d, q_b.size(), exp_q.size());
      end
    end
    total++; if (pr_b != 1) begin bad++; $display("FAIL lane_pix_ready: got %0d want 1", pr_b); end
    total++; if (dn_b != 1) begin bad++; $display("FAIL lane_done: got %0d want 1", dn_b); end
    d = dn_cyc_b - st_cyc_b;
    total++;
    if (d < refresh_len(1, 2) - 1 || d > refresh_len(1, 2) + 1) begin
      bad++; $display("FAIL lane_len: got %0d want 1081", d);
    end
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.led_num = '0; bus_a.brightness = '0; bus_a.pix_data = '0;
    bus_b.start = 1'b0; bus_b.led_num = '0; bus_b.brightness = '0; bus_b.pix_data = '0;
    bus_b.pix_valid = 1'b1;
    test_reset();
    test_basic();
    test_underrun();
    test_zero();
    test_back_to_back();
    test_abort();
    test_multi_lane();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
